// File: rtl/pkt_lane_reducer.sv
// pkt_lane_reducer: folds each input packet into one result beat
// holding per-lane wrapping sums, a saturating beat count and an overlong flag.
module pkt_lane_reducer #(
  parameter int DATA_W    = 512,
  parameter int LANE_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_BEATS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic              io_in_bits_last,
  input  logic [DATA_W-1:0] io_in_bits_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_out_bits_last,
  output logic [DATA_W-1:0] io_out_bits_data,
  output logic [CNT_W-1:0]  io_out_bits_beats,
  output logic              io_out_bits_overlong,
  output logic [31:0]       io_pkt_count
);
  localparam int NLANES = DATA_W / LANE_W;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] lane_sum;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  cnt_sat;
  logic [CNT_W-1:0]  out_beats;
  logic [CNT_W:0]    cnt_inc;
  logic              over;
  logic              out_overlong;
  logic [31:0]       pkt_count;
  logic              out_valid;
  logic              in_fire;
  logic              last_fire;
  logic              out_fire;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign lane_sum[i*LANE_W +: LANE_W] =
      acc[i*LANE_W +: LANE_W] + io_in_bits_data[i*LANE_W +: LANE_W];
  end

  // overlong uses the unsaturated count so it stays set once saturated
  assign cnt_inc = {1'b0, beat_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
  assign over    = cnt_inc > (CNT_W+1)'(MAX_BEATS);

  assign out_valid   = (state == HOLD);
  assign io_in_ready = !out_valid || io_out_ready;
  assign in_fire     = io_in_valid && io_in_ready;
  assign last_fire   = in_fire && io_in_bits_last;
  assign out_fire    = out_valid && io_out_ready;

  assign io_out_valid         = out_valid;
  assign io_out_bits_last     = out_valid;
  assign io_out_bits_data     = out_data;
  assign io_out_bits_beats    = out_beats;
  assign io_out_bits_overlong = out_overlong;
  assign io_pkt_count         = pkt_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (last_fire) state_nx = HOLD;
      HOLD:  if (out_fire && !last_fire) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      beat_cnt     <= '0;
      out_data     <= '0;
      out_beats    <= '0;
      out_overlong <= 1'b0;
      pkt_count    <= '0;
    end else begin
      if (out_fire) pkt_count <= pkt_count + 32'd1;
      if (in_fire) begin
        if (io_in_bits_last) begin
          out_data     <= lane_sum;
          out_beats    <= cnt_sat;
          out_overlong <= over;
          acc          <= '0;
          beat_cnt     <= '0;
        end else begin
          acc      <= lane_sum;
          beat_cnt <= cnt_sat;
        end
      end
    end
  end
endmodule

// File: tb/tb_pkt_lane_reducer.sv
// tb_pkt_lane_reducer: directed tables, hand sequences and a random run
// checked against a per-packet lane-sum reference model.
module tb_pkt_lane_reducer;
  localparam int DATA_W = 512;
  localparam int LANE_W = 32;
  localparam int NL     = DATA_W / LANE_W;
  localparam int CNT_W  = 16;
  localparam int MAXB   = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_beats;
  logic              out_ovl;
  logic [31:0]       pkt_count;

  int checks = 0;
  int errors = 0;

  pkt_lane_reducer #(
    .DATA_W(DATA_W), .LANE_W(LANE_W), .CNT_W(CNT_W), .MAX_BEATS(MAXB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_in_valid(in_valid),
    .io_in_ready(in_ready),
    .io_in_bits_last(in_last),
    .io_in_bits_data(in_data),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_out_bits_last(out_last),
    .io_out_bits_data(out_data),
    .io_out_bits_beats(out_beats),
    .io_out_bits_overlong(out_ovl),
    .io_pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] lanes(input logic [LANE_W-1:0] v);
    return {NL{v}};
  endfunction

  // reference model: per-packet lane sums and counts, one held result
  int unsigned       lsum [NL] = '{default: 0};
  int                nb = 0;
  bit                mv = 0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_beats = 0;
  bit                m_ovl = 0;
  int unsigned       m_pkts = 0;
  bit                er;
  bit                acc_b;

  always @(negedge clock) begin
    if (reset) begin
      foreach (lsum[l]) lsum[l] = 0;
      nb = 0; mv = 0; m_pkts = 0;
    end else begin
      er = !mv || out_ready;
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, mv);
      chk("out_last", out_last, mv);
      if (mv) begin
        chk("out_data", out_data, m_data);
        chk("out_beats", out_beats, m_beats);
        chk("out_overlong", out_ovl, m_ovl);
      end
      chk("pkt_count", pkt_count, m_pkts);
      acc_b = in_valid && er;
      if (mv && out_ready) begin m_pkts++; mv = 0; end
      if (acc_b) begin
        foreach (lsum[l]) lsum[l] += in_data[l*LANE_W +: LANE_W];
        nb++;
        if (in_last) begin
          foreach (lsum[l]) m_data[l*LANE_W +: LANE_W] = lsum[l];
          m_beats = (nb > 65535) ? 65535 : nb;
          m_ovl = (nb > MAXB);
          mv = 1;
          foreach (lsum[l]) lsum[l] = 0;
          nb = 0;
        end
      end
    end
  end

  // called at posedge+2; returns at posedge+2 after the beat is taken
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l,
                           output int waits);
    in_valid = 1'b1; in_data = d; in_last = l; waits = 0;
    @(negedge clock);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clock);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready %0b after %0d cycles, need 1",
               in_ready, waits);
    end
    @(posedge clock); #2;
  endtask

  task automatic send_pkt(input int n, input logic [LANE_W-1:0] v);
    int w;
    for (int i = 0; i < n; i++) send_beat(lanes(v), i == n - 1, w);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [31:0] lane;
    logic [31:0] exp_lane;
    int          exp_beats;
    bit          exp_ovl;
  } vec_t;

  vec_t              vt [6];
  logic [7:0]        bb [3];
  logic [DATA_W-1:0] d;
  int                w;
  int unsigned       p0;
  bit                took;

  initial begin
    vt[0] = '{4, 32'd0, 32'd0,  4,  1'b0};
    vt[1] = '{4, 32'd1, 32'd4,  4,  1'b0};
    vt[2] = '{4, 32'd2, 32'd8,  4,  1'b0};
    vt[3] = '{4, 32'd3, 32'd12, 4,  1'b0};
    vt[4] = '{65, 32'd1, 32'h41, 65, 1'b1};
    vt[5] = '{64, 32'd1, 32'h40, 64, 1'b0};
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock); #2;
    reset = 1'b0;

    // equal-lane packets and the overlong boundary
    for (int i = 0; i < 6; i++) begin
      send_pkt(vt[i].n, vt[i].lane);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, lanes(vt[i].exp_lane));
      chk($sformatf("vec%0d_beats", i), out_beats, vt[i].exp_beats);
      chk($sformatf("vec%0d_ovl", i), out_ovl, vt[i].exp_ovl);
      if (i == 3) begin
        @(posedge clock); #2;
        chk("pkt_count_4", pkt_count, 4);
      end
    end

    // back-to-back single-beat packets
    for (int i = 0; i < 3; i++) begin
      send_beat(lanes({24'd0, bb[i]}), 1'b1, w);
      chk($sformatf("b2b%0d_stall", i), w, 0);
      chk($sformatf("b2b%0d_data", i), out_data, lanes({24'd0, bb[i]}));
      chk($sformatf("b2b%0d_beats", i), out_beats, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;

    // lane wrap without cross-lane carry
    d = '0; d[31:0] = 32'hFFFF_FFFF;
    send_beat(d, 1'b0, w);
    d = '0; d[31:0] = 32'h2;
    send_beat(d, 1'b1, w);
    in_valid = 1'b0; in_last = 1'b0;
    d = '0; d[31:0] = 32'h1;
    chk("wrap_data", out_data, d);
    chk("wrap_lane1", out_data[63:32], 0);

    // backpressure holds the result and blocks input
    send_pkt(4, 32'd7);
    out_ready = 1'b0; p0 = m_pkts;
    in_valid = 1'b1; in_data = lanes(32'd9); in_last = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, lanes(32'd28));
      chk("bp_hold_valid", out_valid, 1);
    end
    chk("bp_pkt_hold", pkt_count, p0);
    @(posedge clock); #2;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clock); #2;
    out_ready = 1'b0;
    chk("bp_pkt_fire", pkt_count, p0 + 1);
    chk("bp_drained", out_valid, 0);
    send_beat(lanes(32'd9), 1'b0, w);
    send_beat(lanes(32'd9), 1'b0, w);
    send_beat(lanes(32'd9), 1'b1, w);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_pkt2_data", out_data, lanes(32'd36));
    chk("bp_pkt2_beats", out_beats, 4);
    out_ready = 1'b1;

    // asynchronous reset in the middle of a packet
    send_beat(lanes(32'd3), 1'b0, w);
    send_beat(lanes(32'd3), 1'b0, w);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_pkt_count", pkt_count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_beats", out_beats, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    send_pkt(4, 32'd5);
    chk("arst_next_data", out_data, lanes(32'd20));
    chk("arst_next_beats", out_beats, 4);
    @(posedge clock); #2;
    chk("arst_next_count", pkt_count, 1);

    // random traffic against the model
    took = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_last = ($urandom_range(0, (c < 1500) ? 3 : 80) == 0);
        for (int l = 0; l < NL; l++) in_data[l*LANE_W +: LANE_W] = $urandom;
      end
      @(negedge clock);
      took = in_valid && in_ready;
      @(posedge clock); #2;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    chk("final_pkt_count", pkt_count, m_pkts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_lane_reducer.md
Name: pkt_lane_reducer

Overview:
- Downstream consumer of the Accelerator output stream (last, 512-bit data).
- Reduces each packet to one result beat: per-lane wrapping sum of all beats in the packet, the packet's beat count and an overlong flag.
- One-entry output register with valid/ready handshake; feeds result sinks or host write-back.

Parameters:
DATA_W, 512, stream data width; must be a multiple of LANE_W
LANE_W, 32, lane width; NLANES = DATA_W/LANE_W (16 by default)
CNT_W, 16, width of the beat counter
MAX_BEATS, 64, beat count above which a packet is flagged overlong

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
io_in_valid  in  1  input beat valid
io_in_ready  out  1  input beat accepted when valid && ready
io_in_bits_last  in  1  final beat of packet
io_in_bits_data  in  DATA_W  beat payload
io_out_valid  out  1  result beat valid
io_out_ready  in  1  downstream accepts result
io_out_bits_last  out  1  always 1 while io_out_valid (one beat per packet)
io_out_bits_data  out  DATA_W  per-lane packet sum
io_out_bits_beats  out  CNT_W  beats in packet, saturating
io_out_bits_overlong  out  1  beat count > MAX_BEATS
io_pkt_count  out  32  packets emitted, wraps at 2^32

Behaviour:
- Reset (async assert, sync release): all of the following clear:
  - acc (NLANES x LANE_W): 0
  - beat_cnt: 0
  - out_valid: 0
  - out_data, out_beats, out_overlong: 0
  - pkt_count: 0
- All state updates on rising clock edges only.
- Output mapping:
  - io_out_valid = out_valid.
  - io_out_bits_last = out_valid.
  - io_out_bits_data/beats/overlong = their registers.
  - io_pkt_count = pkt_count.
- io_in_ready = !out_valid || io_out_ready.
  - Combinational from io_out_ready; the only in-to-out comb path.
  - Asserted out of reset.
  - Applies to every beat, last or not.
- Lane arithmetic: lane i = data[i*LANE_W +: LANE_W]; all sums modulo 2^LANE_W; no carry between lanes.
- Accepted non-last beat:
  - acc[i] <= acc[i] + lane_i.
  - beat_cnt <= sat(beat_cnt + 1), saturating at 2^CNT_W-1.
- Accepted last beat:
  - out_data lane i <= acc[i] + lane_i.
  - out_beats <= sat(beat_cnt + 1).
  - out_overlong <= (beat_cnt + 1 > MAX_BEATS), computed on the unsaturated value, held sticky if saturated.
  - out_valid <= 1; acc <= 0; beat_cnt <= 0.
  - Result visible the cycle after the last beat is accepted (latency 1).
- Output handshake:
  - Fire when out_valid && io_out_ready: pkt_count <= pkt_count + 1.
  - out_valid <= 0 unless a new last beat is accepted the same cycle.
  - Simultaneous fire and last-beat accept: new result loads; out_valid stays 1; back-to-back single-beat packets run at 1 result per cycle.
- Hold under backpressure: while out_valid && !io_out_ready, output registers are stable and no input is accepted.
- Empty packets cannot exist; every packet has at least 1 beat.
- io_in_valid may deassert mid-packet; acc and beat_cnt hold.
- Reset mid-packet discards the partial packet and any unconsumed result; nothing is emitted for it.
- No FSM beyond the out_valid bit: state ACCUM (out_valid=0) / HOLD (out_valid=1).
  - ACCUM->HOLD on last accept.
  - HOLD->ACCUM on fire without a new last.
  - HOLD->HOLD on stall or fire+last.

Test Plan:
1. io_out_ready=1. Send 4 packets of 4 beats, each beat of packet k has every lane = k (k=0..3; last on the 4th) -> 4 results, all lanes = 4k (0,4,8,12), beats=4, overlong=0, io_pkt_count=4; each result 1 cycle after its last beat.
2. Back-to-back single-beat packets, data lanes = 0x11,0x22,0x33, continuous valid, io_out_ready=1 -> io_in_ready constantly 1; 3 results on consecutive cycles, beats=1, data equals input.
3. Wrap: 2-beat packet with lane0 0xFFFFFFFF then 0x00000002, other lanes 0 -> lane0 = 0x00000001, lane1 = 0 (no cross-lane carry).
4. Backpressure: io_out_ready=0 after the first 4-beat packet, then present the next packet -> io_in_ready=0, result stable; raise io_out_ready for 1 cycle -> result consumed, io_in_ready=1, second packet proceeds; pkt_count increments once per fire.
5. Overlong: 65-beat packet, all lanes 1 -> lanes = 65 (0x41), beats=65, overlong=1; a 64-beat packet gives overlong=0.
6. Reset asserted asynchronously after 2 beats of a packet (between edges) -> outputs clear immediately; a following 4-beat packet of lanes=5 yields lanes 20, beats=4, pkt_count=1.
